// File: rtl/io_bus_pkg.sv
// ============================================================================
// Module  : io_bus_pkg
// Purpose : Shared types and constants for the Minisys I/O bus sequencer.
//           Holds the sequencer state encoding, the device index map of the
//           I/O window, the upper address bits of that window and the default
//           wait/timeout settings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Device index = addr[6:4] inside the I/O window.
  localparam logic [2:0] TUBE     = 3'd0;
  localparam logic [2:0] KEYBOARD = 3'd1;
  localparam logic [2:0] TIMER    = 3'd2;
  localparam logic [2:0] PWM      = 3'd3;
  localparam logic [2:0] UART     = 3'd4;
  localparam logic [2:0] WDOG     = 3'd5;
  localparam logic [2:0] LED      = 3'd6;
  localparam logic [2:0] SWITCH   = 3'd7;

  // Upper 22 address bits of the 0xFFFFFC00-0xFFFFFFFF window.
  localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;

  localparam int unsigned DEF_WAIT_CYC = 1;
  localparam int unsigned DEF_TIMEOUT  = 64;

  // One-hot chip-select for a device index.
  function automatic logic [7:0] dev_onehot(input logic [2:0] idx);
    logic [7:0] sel;
    sel      = 8'h00;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_wait_timer.sv
// ============================================================================
// Module  : io_wait_timer
// Purpose : Wait-state and timeout down-counters for one I/O access.
//           load_i presets both counters; dec_i counts them down, each one
//           saturating at zero.
// Ports   : clock, reset       - clock, async active-high reset
//           load_i             - preset counters to WAIT_CYC / TIMEOUT
//           dec_i              - decrement (one ACCESS cycle elapsed)
//           wait_zero_o        - wait-state counter is zero, ready may count
//           timeout_zero_o     - timeout counter reaches zero on this cycle
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module io_wait_timer
  import io_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYC = DEF_WAIT_CYC,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic wait_zero_o,
  output logic timeout_zero_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
  localparam logic [7:0] TMO_INIT  = 8'(TIMEOUT);

  logic [3:0] wait_q, wait_d;
  logic [7:0] tmo_q,  tmo_d;

  always_comb begin
    wait_d = wait_q;
    tmo_d  = tmo_q;
    if (load_i) begin
      wait_d = WAIT_INIT;
      tmo_d  = TMO_INIT;
    end else if (dec_i) begin
      if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
      if (tmo_q  != 8'd0) tmo_d  = tmo_q  - 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_q <= 4'd0;
      tmo_q  <= 8'd0;
    end else begin
      wait_q <= wait_d;
      tmo_q  <= tmo_d;
    end
  end

  assign wait_zero_o    = (wait_q == 4'd0);
  // The counter holds TIMEOUT in the first ACCESS cycle, so the cycle in
  // which it shows 1 is the last one: its decrement takes it to zero.
  assign timeout_zero_o = (tmo_q <= 8'd1);

endmodule

`default_nettype wire

// File: rtl/io_bus_sequencer.sv
// ============================================================================
// Module  : io_bus_sequencer
// Purpose : Multi-cycle sequencer between the CPU's IORead/IOWrite strobes and
//           the 8-device peripheral bus. Stalls the CPU, drives chip-select
//           and read/write strobe with wait states, waits for io_ready or a
//           timeout, then returns read data and releases the stall.
// Ports   : clock, reset          - clock, async active-high reset
//           IORead, IOWrite       - I/O load / store request of current instr
//           addr[9:0]             - low address bits of the ALU result
//           wdata                 - store data
//           io_ready, io_rdata    - device handshake and read data
//           stall                 - freeze PC / pipeline (combinational)
//           io_cs[7:0]            - one-hot device select (registered)
//           io_rd, io_wr          - bus strobes (registered)
//           io_addr[3:0], io_wdata- register offset and store data (registered)
//           rdata                 - read data to write-back, valid in DONE
//           err, err_sticky       - access failed pulse / sticky error flag
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module io_bus_sequencer
  import io_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYC = DEF_WAIT_CYC,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IORead,
  input  logic              IOWrite,
  input  logic [9:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              io_ready,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              stall,
  output logic [7:0]        io_cs,
  output logic              io_rd,
  output logic              io_wr,
  output logic [3:0]        io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              err_sticky
);

  state_e            state_q;
  logic [7:0]        cs_q;
  logic              rd_q;
  logic              wr_q;
  logic [3:0]        io_addr_q;
  logic [DATA_W-1:0] io_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              err_sticky_q;

  logic req;
  logic req_valid;
  logic tmr_load;
  logic tmr_dec;
  logic wait_zero;
  logic timeout_zero;
  logic accept;
  logic expire;

  assign req       = IORead | IOWrite;
  // Exactly one strobe and an address inside the 8 x 16-register device area.
  assign req_valid = (IORead ^ IOWrite) && (addr[9:7] == 3'b000);

  assign tmr_load  = (state_q == IDLE) && req && req_valid;
  assign tmr_dec   = (state_q == ACCESS);
  assign accept    = (state_q == ACCESS) && wait_zero && io_ready;
  // Ready on the last allowed cycle still completes the access cleanly.
  assign expire    = (state_q == ACCESS) && timeout_zero && !accept;

  io_wait_timer #(
    .WAIT_CYC (WAIT_CYC),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clock          (clock),
    .reset          (reset),
    .load_i         (tmr_load),
    .dec_i          (tmr_dec),
    .wait_zero_o    (wait_zero),
    .timeout_zero_o (timeout_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cs_q         <= 8'h00;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      io_addr_q    <= 4'h0;
      io_wdata_q   <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (req_valid) begin
              cs_q       <= dev_onehot(addr[6:4]);
              rd_q       <= IORead;
              wr_q       <= IOWrite;
              io_addr_q  <= addr[3:0];
              io_wdata_q <= wdata;
              state_q    <= ACCESS;
            end else begin
              // Rejected request: straight to DONE, bus stays quiet.
              err_q        <= 1'b1;
              err_sticky_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        ACCESS: begin
          if (accept) begin
            if (rd_q) rdata_q <= io_rdata;
            cs_q    <= 8'h00;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= DONE;
          end else if (expire) begin
            rdata_q      <= '0;
            err_q        <= 1'b1;
            err_sticky_q <= 1'b1;
            cs_q         <= 8'h00;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            state_q      <= DONE;
          end
        end
        DONE: begin
          // Instruction retires here; its still-asserted request is ignored.
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          err_q   <= 1'b0;
          cs_q    <= 8'h00;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = req;
      ACCESS:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign io_cs      = cs_q;
  assign io_rd      = rd_q;
  assign io_wr      = wr_q;
  assign io_addr    = io_addr_q;
  assign io_wdata   = io_wdata_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_sequencer.sv
// ============================================================================
// Module  : tb_io_bus_sequencer
// Purpose : Scoreboard bench for io_bus_sequencer. Two instances with
//           different wait/timeout settings share the data-side inputs; each
//           has its own request strobes. Expected completions are queued by
//           the stimulus and checked by a monitor when an instance reaches
//           DONE (request held while stall is low).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_bus_sequencer;

  logic        clk;
  logic        reset;
  logic        iord [2];
  logic        iowr [2];
  logic [9:0]  addr;
  logic [15:0] wdata;
  logic        io_ready;
  logic [15:0] io_rdata;

  logic        stall_o  [2];
  logic [7:0]  cs_o     [2];
  logic        rd_o     [2];
  logic        wr_o     [2];
  logic [3:0]  ioaddr_o [2];
  logic [15:0] iowd_o   [2];
  logic [15:0] rdata_o  [2];
  logic        err_o    [2];
  logic        stk_o    [2];

  int passed;
  int total;

  typedef struct {
    int          inst;
    logic [7:0]  cs;
    logic        rd;
    logic        wr;
    int          cs_cyc;
    int          stall_cyc;
    logic [3:0]  ioaddr;
    logic        chk_wdata;
    logic [15:0] wdata;
    logic        chk_rdata;
    logic [15:0] rdata;
    logic        err;
    logic        sticky;
  } exp_t;

  exp_t exp_q[$];

  // inst 0: no wait states, timeout 8
  io_bus_sequencer #(.WAIT_CYC(0), .TIMEOUT(8), .DATA_W(16)) dut0 (
    .clock(clk), .reset(reset), .IORead(iord[0]), .IOWrite(iowr[0]),
    .addr(addr), .wdata(wdata), .io_ready(io_ready), .io_rdata(io_rdata),
    .stall(stall_o[0]), .io_cs(cs_o[0]), .io_rd(rd_o[0]), .io_wr(wr_o[0]),
    .io_addr(ioaddr_o[0]), .io_wdata(iowd_o[0]), .rdata(rdata_o[0]),
    .err(err_o[0]), .err_sticky(stk_o[0])
  );

  // inst 1: 3 wait states, timeout 4 (ready and timeout coincide)
  io_bus_sequencer #(.WAIT_CYC(3), .TIMEOUT(4), .DATA_W(16)) dut1 (
    .clock(clk), .reset(reset), .IORead(iord[1]), .IOWrite(iowr[1]),
    .addr(addr), .wdata(wdata), .io_ready(io_ready), .io_rdata(io_rdata),
    .stall(stall_o[1]), .io_cs(cs_o[1]), .io_rd(rd_o[1]), .io_wr(wr_o[1]),
    .io_addr(ioaddr_o[1]), .io_wdata(iowd_o[1]), .rdata(rdata_o[1]),
    .err(err_o[1]), .err_sticky(stk_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic monitor_loop();
    int          sc  [2];
    int          cc  [2];
    logic [7:0]  cor [2];
    logic        srd [2];
    logic        swr [2];
    logic [3:0]  sa  [2];
    logic [15:0] sw  [2];
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      sc[i] = 0; cc[i] = 0; cor[i] = 0; srd[i] = 0; swr[i] = 0; sa[i] = 0; sw[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          sc[i] = 0; cc[i] = 0; cor[i] = 0; srd[i] = 0; swr[i] = 0; sa[i] = 0; sw[i] = 0;
        end else if ((iord[i] | iowr[i]) && !stall_o[i]) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL d%0d_unexpected_done: completion seen, none pending", i);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("d%0d_inst", i), i, e.inst);
            check($sformatf("d%0d_cs", i), {24'h0, cor[i]}, {24'h0, e.cs});
            check($sformatf("d%0d_rd", i), {31'h0, srd[i]}, {31'h0, e.rd});
            check($sformatf("d%0d_wr", i), {31'h0, swr[i]}, {31'h0, e.wr});
            check($sformatf("d%0d_cs_cycles", i), cc[i], e.cs_cyc);
            check($sformatf("d%0d_stall_cycles", i), sc[i], e.stall_cyc);
            check($sformatf("d%0d_io_addr", i), {28'h0, sa[i]}, {28'h0, e.ioaddr});
            if (e.chk_wdata)
              check($sformatf("d%0d_io_wdata", i), {16'h0, sw[i]}, {16'h0, e.wdata});
            if (e.chk_rdata)
              check($sformatf("d%0d_rdata", i), {16'h0, rdata_o[i]}, {16'h0, e.rdata});
            check($sformatf("d%0d_err", i), {31'h0, err_o[i]}, {31'h0, e.err});
            check($sformatf("d%0d_err_sticky", i), {31'h0, stk_o[i]}, {31'h0, e.sticky});
            check($sformatf("d%0d_done_bus_idle", i),
                  {22'h0, cs_o[i], rd_o[i], wr_o[i]}, 32'h0);
          end
          sc[i] = 0; cc[i] = 0; cor[i] = 0; srd[i] = 0; swr[i] = 0; sa[i] = 0; sw[i] = 0;
        end else begin
          if (stall_o[i]) sc[i]++;
          if (cs_o[i] != 8'h00) begin
            cc[i]++;
            cor[i] |= cs_o[i];
            srd[i] |= rd_o[i];
            swr[i] |= wr_o[i];
            sa[i]  = ioaddr_o[i];
            sw[i]  = iowd_o[i];
          end
        end
      end
    end
  endtask

  // Queue the expected completion, raise the request and hold it until the
  // instance retires it (or a cycle budget runs out).
  task automatic access(input int inst, input logic r, input logic w,
                        input logic [9:0] a, input logic [15:0] wd,
                        input logic [15:0] dev_data, input logic rdy,
                        input logic [7:0] e_cs, input int e_cscyc, input int e_stall,
                        input logic e_chkrd, input logic [15:0] e_rdata,
                        input logic e_err, input logic e_sticky, input logic keep);
    exp_t e;
    logic done;
    e.inst      = inst;
    e.cs        = e_cs;
    e.rd        = (e_cs != 8'h00) ? r : 1'b0;
    e.wr        = (e_cs != 8'h00) ? w : 1'b0;
    e.cs_cyc    = e_cscyc;
    e.stall_cyc = e_stall;
    e.ioaddr    = (e_cs != 8'h00) ? a[3:0] : 4'h0;
    e.chk_wdata = w && (e_cs != 8'h00);
    e.wdata     = wd;
    e.chk_rdata = e_chkrd;
    e.rdata     = e_rdata;
    e.err       = e_err;
    e.sticky    = e_sticky;
    exp_q.push_back(e);
    @(posedge clk); #1;
    iord[inst] = r;
    iowr[inst] = w;
    addr       = a;
    wdata      = wd;
    io_rdata   = dev_data;
    io_ready   = rdy;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall_o[inst]) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      $display("FAIL d%0d_completion_timeout: stall still %0b after 40 cycles, expected release",
               inst, stall_o[inst]);
    end
    if (!keep) begin
      @(posedge clk); #1;
      iord[inst] = 1'b0;
      iowr[inst] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stimulus();
    // ---- reset state ----
    #3;
    check("rst_cs", {24'h0, cs_o[0]}, 32'h0);
    check("rst_strobes", {30'h0, rd_o[0], wr_o[0]}, 32'h0);
    check("rst_rdata", {16'h0, rdata_o[0]}, 32'h0);
    check("rst_err", {30'h0, err_o[0], stk_o[0]}, 32'h0);
    check("rst_stall_noreq", {31'h0, stall_o[0]}, 32'h0);
    iord[0] = 1'b1; #1;
    check("rst_stall_req", {31'h0, stall_o[0]}, 32'h1);
    iord[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // ---- inst 0 (WAIT_CYC=0, TIMEOUT=8) ----
    // SWITCH read
    access(0, 1, 0, 10'h070, 16'h0000, 16'hA5A5, 1, 8'h80, 1, 2, 1, 16'hA5A5, 0, 0, 0);
    idle(2);
    // KEYBOARD then UART back-to-back
    access(0, 1, 0, 10'h014, 16'h0000, 16'h1111, 1, 8'h02, 1, 2, 1, 16'h1111, 0, 0, 1);
    access(0, 1, 0, 10'h04C, 16'h0000, 16'h5A3C, 1, 8'h10, 1, 2, 1, 16'h5A3C, 0, 0, 0);
    idle(2);
    // TIMER read, device never ready: 8 ACCESS cycles then error
    access(0, 1, 0, 10'h025, 16'h0000, 16'hDEAD, 0, 8'h04, 8, 9, 1, 16'h0000, 1, 1, 0);
    idle(2);
    // out-of-window address
    access(0, 1, 0, 10'h380, 16'h0000, 16'h7777, 1, 8'h00, 0, 1, 0, 16'h0000, 1, 1, 0);
    idle(2);
    // both strobes
    access(0, 1, 1, 10'h010, 16'h1234, 16'h7777, 1, 8'h00, 0, 1, 0, 16'h0000, 1, 1, 0);
    idle(2);

    // ---- inst 1 (WAIT_CYC=3, TIMEOUT=4) ----
    // LED write: 4 ACCESS cycles, ready and timeout coincide -> no error
    access(1, 0, 1, 10'h062, 16'h00FF, 16'h1234, 1, 8'h40, 4, 5, 1, 16'h0000, 0, 0, 0);
    idle(2);
    // both strobes -> error, sets sticky
    access(1, 1, 1, 10'h062, 16'h00FF, 16'h1234, 1, 8'h00, 0, 1, 0, 16'h0000, 1, 1, 0);
    idle(2);

    // ---- reset in ACCESS cycle 2 ----
    iowr[1]  = 1'b1;
    addr     = 10'h062;
    wdata    = 16'hBEEF;
    io_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_cs", {24'h0, cs_o[1]}, 32'h40);
    check("pre_rst_wr", {31'h0, wr_o[1]}, 32'h1);
    reset = 1'b1; #1;
    check("mid_rst_cs", {24'h0, cs_o[1]}, 32'h0);
    check("mid_rst_wr", {31'h0, wr_o[1]}, 32'h0);
    check("mid_rst_sticky", {31'h0, stk_o[1]}, 32'h0);
    check("mid_rst_io_addr", {28'h0, ioaddr_o[1]}, 32'h0);
    check("mid_rst_io_wdata", {16'h0, iowd_o[1]}, 32'h0);
    check("mid_rst_stall_idle_req", {31'h0, stall_o[1]}, 32'h1);
    iowr[1] = 1'b0; #1;
    check("mid_rst_stall_idle_noreq", {31'h0, stall_o[1]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // ---- inst 1 after reset: clean read of WDOG ----
    access(1, 1, 0, 10'h053, 16'h0000, 16'hC3C3, 1, 8'h20, 4, 5, 1, 16'hC3C3, 0, 0, 0);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    reset    = 1'b1;
    iord[0]  = 1'b0;
    iord[1]  = 1'b0;
    iowr[0]  = 1'b0;
    iowr[1]  = 1'b0;
    addr     = 10'h000;
    wdata    = 16'h0000;
    io_ready = 1'b0;
    io_rdata = 16'h0000;
    fork
      monitor_loop();
      stimulus();
    join_any
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
